// File: rtl/skew_feeder.sv
// rtl/skew_feeder.sv - ping-pong operand buffer that replays a square matrix as a diagonal wavefront
// Lane j of drain step t carries element k = t - j of row/column j, zero outside the active N x N window.
module skew_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int SZBITS  = $clog2(DIM + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_transpose,
  input  logic [SZBITS-1:0]            cfg_size,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DIM-1:0][BITS_AB-1:0]  in_data,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [DIM-1:0][BITS_AB-1:0]  out_data,
  output logic                         out_first,
  output logic                         out_last
);
  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int TW = SZBITS + 1;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  bank_state_t        st     [2];
  bank_state_t        st_nxt [2];
  logic               bank_mode [2];
  logic [SZBITS-1:0]  bank_n    [2];
  logic [BITS_AB-1:0] mem [2][DIM][DIM];

  logic              wr_sel, wr_sel_nxt;
  logic              rd_sel, rd_sel_nxt;
  logic              rd_oth;
  logic [IW-1:0]     wr_row, wr_row_nxt;
  logic [TW-1:0]     t, t_nxt, last_t;
  logic              ready_en;
  logic [SZBITS-1:0] cfg_n, wr_n;
  logic              wr_fire, rd_fire, wr_first;

  assign cfg_n = (cfg_size == '0 || cfg_size > SZBITS'(DIM)) ? SZBITS'(DIM) : cfg_size;

  assign rd_oth    = ~rd_sel;
  assign in_ready  = ready_en && (st[wr_sel] == EMPTY || st[wr_sel] == FILLING);
  assign out_valid = (st[rd_sel] == DRAINING);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_first  = (st[wr_sel] == EMPTY);
  assign wr_n      = wr_first ? cfg_n : bank_n[wr_sel];
  assign last_t    = {bank_n[rd_sel], 1'b0} - TW'(2);

  // Write side only touches EMPTY/FILLING banks, read side only FULL/DRAINING, so updates never collide.
  always_comb begin
    st_nxt     = st;
    wr_sel_nxt = wr_sel;
    rd_sel_nxt = rd_sel;
    wr_row_nxt = wr_row;
    t_nxt      = t;
    if (wr_fire) begin
      if (SZBITS'(wr_row) == wr_n - SZBITS'(1)) begin
        st_nxt[wr_sel] = FULL;
        wr_row_nxt     = '0;
        wr_sel_nxt     = ~wr_sel;
      end else begin
        st_nxt[wr_sel] = FILLING;
        wr_row_nxt     = wr_row + IW'(1);
      end
    end
    if (st[rd_sel] == FULL) begin
      st_nxt[rd_sel] = DRAINING;
    end
    if (rd_fire) begin
      if (t == last_t) begin
        st_nxt[rd_sel] = EMPTY;
        rd_sel_nxt     = rd_oth;
        t_nxt          = '0;
        if (st[rd_oth] == FULL) begin
          st_nxt[rd_oth] = DRAINING;
        end
      end else begin
        t_nxt = t + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st[0]        <= EMPTY;
      st[1]        <= EMPTY;
      bank_mode[0] <= 1'b0;
      bank_mode[1] <= 1'b0;
      bank_n[0]    <= '0;
      bank_n[1]    <= '0;
      wr_sel       <= 1'b0;
      rd_sel       <= 1'b0;
      wr_row       <= '0;
      t            <= '0;
      ready_en     <= 1'b0;
    end else begin
      st[0]    <= st_nxt[0];
      st[1]    <= st_nxt[1];
      wr_sel   <= wr_sel_nxt;
      rd_sel   <= rd_sel_nxt;
      wr_row   <= wr_row_nxt;
      t        <= t_nxt;
      ready_en <= 1'b1;
      if (wr_fire && wr_first) begin
        bank_mode[wr_sel] <= cfg_transpose;
        bank_n[wr_sel]    <= cfg_n;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < DIM; r++) begin
          for (int c = 0; c < DIM; c++) begin
            mem[b][r][c] <= '0;
          end
        end
      end
    end else if (wr_fire) begin
      for (int c = 0; c < DIM; c++) begin
        mem[wr_sel][wr_row][c] <= in_data[c];
      end
    end
  end

  // Output lanes are built purely from registered state, so there is no in_* to out_* path.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < DIM; j++) begin
      int k;
      k = int'(t) - j;
      if (out_valid && k >= 0 && k < int'(bank_n[rd_sel]) && j < int'(bank_n[rd_sel])) begin
        if (bank_mode[rd_sel]) begin
          out_data[j] = mem[rd_sel][IW'(j)][k[IW-1:0]];
        end else begin
          out_data[j] = mem[rd_sel][k[IW-1:0]][IW'(j)];
        end
      end
    end
  end

  assign out_first = out_valid && (t == '0);
  assign out_last  = out_valid && (t == last_t);

endmodule

// File: doc/skew_feeder.md
Name: skew_feeder

Overview:
- Parametrised successor to the single-bank B-skew memory that feeds the systolic array.
- Accepts a square operand matrix one vector per beat and replays it as a diagonal wavefront: lane j is delayed j beats.
- New versus the previous block:
  - runtime row/column (transpose) mode, so one block serves both A and B;
  - runtime active size up to DIM;
  - ping-pong double buffering, so the next matrix loads while the current one drains;
  - valid/ready handshakes on both sides.

Parameters:
BITS_AB, 8, signed element width
DIM, 8, maximum matrix dimension and number of output lanes
SZBITS, $clog2(DIM+1), width of the size field (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
cfg_transpose  input  1  0: lane j = column j of the loaded rows (B mode); 1: lane j = row j (A mode)
cfg_size  input  SZBITS  active dimension N; 0 or >DIM treated as DIM
in_valid  input  1  in_data holds one row
in_ready  output  1  a bank can accept the row
in_data  input  DIM x BITS_AB signed  row r, element c on index c
out_ready  input  1  consumer advances the wavefront
out_valid  output  1  out_data is a drain beat
out_data  output  DIM x BITS_AB signed  skewed lane values
out_first  output  1  high on drain step 0
out_last  output  1  high on drain step 2N-2

Behaviour:
- Storage: two banks of DIM x DIM x BITS_AB. Each bank has state EMPTY, FILLING, FULL or DRAINING, plus a latched mode and latched N.
- Write side:
  - wr_sel points to the bank being written; in_ready = 1 when that bank is EMPTY or FILLING.
  - Transfer occurs on in_valid && in_ready and writes row wr_row.
  - The first row written into an EMPTY bank latches cfg_transpose and cfg_size (clamped). Config changes mid-fill are ignored.
  - After row N-1 the bank goes FULL, wr_row returns to 0 and wr_sel toggles.
- Read side:
  - rd_sel points to the bank being drained. A FULL bank becomes DRAINING on the next edge, so out_valid rises one cycle after the last row transfer when the read side is idle.
  - Step counter t runs 0..2N-2 and advances on out_valid && out_ready.
  - On the transfer with t = 2N-2: the bank goes EMPTY, rd_sel toggles and t returns to 0.
  - If the other bank is already FULL, the next cycle presents its step 0. There is no bubble and out_valid stays high.
- Lane values at step t, with k = t-j:
  - mode 0: lane j = M[k][j];
  - mode 1: lane j = M[j][k];
  - a lane is 0 when k < 0, k >= N, or j >= N.
- When out_valid = 0, out_data, out_first and out_last are all 0.
- With out_ready = 0 while out_valid = 1, out_data, out_first and out_last hold stable.
- No combinational path from in_* to out_*. in_ready depends only on state.
- Simultaneous events:
  - A bank emptied on an edge is writable on the next cycle (no same-cycle reuse).
  - A write filling bank X and a drain finishing bank Y on the same edge are both legal.
- N = 1: a one-beat drain with out_first = out_last = 1, lane 0 = M[0][0].
- Reset (async, any time, including mid-fill or mid-drain):
  - both banks EMPTY and storage cleared to 0;
  - wr_sel = rd_sel = 0, wr_row = t = 0;
  - out_valid = out_first = out_last = 0 and out_data = 0 immediately;
  - in_ready = 0 while rst is high, 1 from the first cycle after release;
  - partial matrices are discarded.

Test Plan:
(all scenarios use DIM=4, BITS_AB=8, M[r][c] = 16r+c)
- Reset: assert rst for 2 cycles -> out_valid=0, out_data all 0, in_ready=0; after release in_ready=1.
- Mode 0, size 4, out_ready=1, 4 rows loaded ->
  - 7 beats, out_valid first seen the cycle after row 3;
  - step0 {00,0,0,0} out_first=1;
  - step1 {10,01,0,0};
  - step3 {30,21,12,03};
  - step6 {0,0,0,33} out_last=1.
- Mode 1, same data -> step1 {01,10,0,0}, step3 {03,12,21,30}, step6 {0,0,0,33}.
- cfg_size=2, 2 rows loaded -> 3 beats: {00,0,0,0}, {10,01,0,0}, {0,11,0,0}; lanes 2,3 always 0; cfg changes during fill have no effect.
- Ping-pong with backpressure:
  - hold out_ready=0 and load X then Y; the 9th row sees in_ready=0;
  - hold out_ready=0 for 5 cycles at step 2 -> data stable;
  - release -> 7 beats of X, then Y step 0 in the next cycle with no out_valid gap;
  - in_ready=1 the cycle after X's out_last transfer.
- Reset mid-drain at step 3 -> out_valid=0 asynchronously. Reload with M+1 -> drain values match M+1 exactly, with no residue from the old matrix.
